// File: rtl/mmio_uart_tx_pkg.sv
// Shared defines for the memory-mapped UART transmitter: register map,
// STATUS bit positions, FSM encodings and the bus request bundle.
package mmio_uart_tx_pkg;

    // Register offsets, selected by addr[3:2]
    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_DIVISOR = 2'd2;

    // STATUS register bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // One data-port access as seen by the peripheral
    typedef struct packed {
        logic        hit;
        logic [1:0]  off;
        logic [1:0]  we;
        logic [15:0] wdata;
    } bus_req_t;

    // A zero divisor behaves as one clock per bit
    function automatic logic [15:0] div_eff(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous circular-buffer FIFO with occupancy count.
// A pop is honoured only when non-empty; a push when full is accepted only
// if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data port. Register reads
// come back one cycle later, matching the data memory, so the core's load
// mux can pick dout whenever hit_q is set.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  mem_we,
    output logic [31:0] dout,
    output logic        hit_q,
    output logic        txd,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_req_t   req;
    tx_state_e  state, state_d;
    logic [15:0] divisor, baud_cnt, cnt_d;
    logic [7:0]  shift, shift_d;
    logic [2:0]  bit_idx, idx_d;
    logic        bit_end, pop, ovf;
    logic        wr_tx, clr_ovf;
    logic [7:0]  fifo_rdata;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0] status_w, rd_data;
    logic        unused_bits;

    // Byte lanes above the divisor width and the word offset never matter here
    assign unused_bits = ^{din[31:16], addr[1:0], mem_we[3:2]};

    // Decode the current access into a compact request
    always_comb begin
        req       = '0;
        req.hit   = (addr[31:4] == BASE_ADDR[31:4]);
        req.off   = addr[3:2];
        req.we    = mem_we[1:0];
        req.wdata = din[15:0];
    end

    assign wr_tx   = req.hit && (req.off == OFF_TXDATA) && req.we[0];
    assign clr_ovf = req.hit && (req.off == OFF_STATUS) && req.we[0];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .pop   (pop),
        .wdata (req.wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The divisor is sampled live, so a mid-frame write applies at the next
    // comparison; shrinking it below the running count lets the counter wrap.
    assign bit_end = (baud_cnt == div_eff(divisor) - 16'd1);
    assign irq     = fifo_empty && (state == S_IDLE);

    // Next-state and serial output; txd is decoded from state so reset
    // forces the line high without waiting for a clock edge.
    always_comb begin
        state_d = state;
        cnt_d   = baud_cnt;
        shift_d = shift;
        idx_d   = bit_idx;
        pop     = 1'b0;
        txd     = 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                txd = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                txd = shift[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift[7:1]};
                    idx_d   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = baud_cnt + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transmitter state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            shift    <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_d;
            baud_cnt <= cnt_d;
            shift    <= shift_d;
            bit_idx  <= idx_d;
        end
    end

    // STATUS snapshot and read mux for the current address
    always_comb begin
        status_w = '0;
        status_w[ST_BUSY]  = (state != S_IDLE);
        status_w[ST_FULL]  = fifo_full;
        status_w[ST_EMPTY] = fifo_empty;
        status_w[ST_OVF]   = ovf;
        status_w[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
        case (req.off)
            OFF_STATUS:  rd_data = status_w;
            OFF_DIVISOR: rd_data = {16'h0, divisor};
            default:     rd_data = '0;
        endcase
    end

    // Control registers and the one-cycle registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor <= DIV_RESET;
            ovf     <= 1'b0;
            dout    <= '0;
            hit_q   <= 1'b0;
        end else begin
            if (req.hit && (req.off == OFF_DIVISOR)) begin
                if (req.we[0]) divisor[7:0]  <= req.wdata[7:0];
                if (req.we[1]) divisor[15:8] <= req.wdata[15:8];
            end
            if (wr_tx && fifo_full && !pop) ovf <= 1'b1;
            else if (clr_ovf)               ovf <= 1'b0;
            dout  <= req.hit ? rd_data : '0;
            hit_q <= req.hit;
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data port, downstream of the core.
- Shares the `alu_out` address, `rs2_val_sx` store data and `mem_we_in` byte-enable bus with `memory`.
- Returns read data with the same one-cycle registered latency as `memory`, so the core's existing load stall path applies unchanged.
- Contains a small TX FIFO and a bit-serial 8N1 transmitter with a programmable divisor.

Parameters:
- BASE_ADDR, 32'h0001_0000: base of the 16-byte register window; bits [3:0] must be zero.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of two, 2..16.
- DIV_RESET, 16'd868: divisor loaded at reset, in clocks per bit.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  data address (core `alu_out`).
- din  input  32  store data, already lane-aligned (core `rs2_val_sx`).
- mem_we  input  4  byte write enables (core `mem_we_in`).
- dout  output  32  registered read data for the address of the previous cycle.
- hit_q  output  1  registered: the previous cycle's addr was in the window; the core's load mux selects dout when this is high.
- txd  output  1  serial output; idle level is high.
- irq  output  1  high while the FIFO is empty and the transmitter is idle.

Behaviour:
- Decode: hit = (addr[31:4] == BASE_ADDR[31:4]). Register offsets are addr[3:2]:
  - 0: TXDATA
  - 1: STATUS
  - 2: DIVISOR
  - 3: reserved (reads 0, writes ignored).
- Writes take effect on the clock edge and only when hit is high.
  - TXDATA: mem_we[0] pushes din[7:0].
  - STATUS: mem_we[0] clears the sticky overflow flag.
  - DIVISOR: mem_we[0] loads bits [7:0], mem_we[1] loads bits [15:8].
- STATUS layout:
  - bit0: busy (FSM not IDLE)
  - bit1: fifo_full
  - bit2: fifo_empty
  - bit3: overflow (sticky)
  - bits[8:4]: FIFO count
  - other bits: 0
- Reads:
  - dout is registered every cycle from the current addr; latency is 1.
  - DIVISOR reads back zero-extended.
  - TXDATA reads 0.
  - When the previous cycle was not a hit, dout = 0.
- Reset values:
  - dout = 0, hit_q = 0, txd = 1, irq = 1.
  - FIFO empty, overflow = 0, divisor = DIV_RESET, FSM = IDLE.
  - An active reset mid-frame forces txd high immediately and discards the FIFO.
- FIFO:
  - Circular buffer with read and write pointers and a count.
  - Push when full with no pop in the same cycle: data dropped, overflow set.
  - Push and pop in the same cycle: both happen and count is unchanged. This holds when full (push accepted) and when count = 1.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: txd = 1. When the FIFO is non-empty: pop into shift register, reset baud counter, go to START. Pop and START entry occur on the same edge.
  - START: txd = 0 for div_eff clocks, then go to DATA with bit index 0.
  - DATA: txd = shift[0] for div_eff clocks per bit, LSB first. After each bit, shift right and increment the index. After bit 7, go to STOP.
  - STOP: txd = 1 for div_eff clocks, then go to IDLE.
  - A frame is 10*div_eff clocks from the START edge. With a non-empty FIFO, the next START follows after exactly one IDLE cycle.
- Divisor:
  - div_eff = (divisor == 0) ? 1 : divisor.
  - Baud counter is 16 bits. It counts 0 .. div_eff-1; the bit ends when the counter equals div_eff-1.
  - A DIVISOR write mid-frame takes effect at the next bit boundary comparison.
- irq = fifo_empty && state == IDLE. It is combinational from registered state.

Decomposition:
- Shared package (core-wide defines file):
  - register offsets: TXDATA = 2'd0, STATUS = 2'd1, DIVISOR = 2'd2
  - STATUS bit positions
  - FSM state encodings (2-bit)
- Sub-module: sync_fifo, parameterised on width (8) and depth, with push, pop, full, empty, count and rdata outputs.
- The FSM, baud counter and register decode stay in mmio_uart_tx.

Test Plan:
1. Reset release -> txd=1, irq=1, dout=0; read STATUS -> next cycle dout = 32'h0000_0004.
2. Write DIVISOR=4, write TXDATA=8'h55 -> txd: start 0 for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, stop 1 for 4 clocks. Frame is 40 clocks. irq low during the frame and high after.
3. Write 5 bytes (0x01..0x05) back-to-back while the FIFO drains; divisor=4, depth 4:
   - first byte popped at once, next four queued, no overflow.
   - a 6th write on the following cycle sets STATUS bit3.
   - writing STATUS with mem_we=4'b0001 clears bit3.
4. DIVISOR=0 with TXDATA=8'hA5 -> each bit lasts 1 clock, frame 10 clocks; bits LSB first 1,0,1,0,0,1,0,1.
5. Assert reset at clock 15 of a 40-clock frame -> txd=1 with no clock edge needed. After release: STATUS reads 0x4, divisor reads DIV_RESET (868).
6. Access to addr = BASE_ADDR+0x20, and a store with mem_we=4'b0010 to TXDATA -> no push, hit_q=0 for the out-of-window access, dout=0.
